// File: rtl/video_path_sequencer.sv
// Sequences the analog video path switches so they never change while video is driven:
// mute, wait for a stable input format, apply the switches, settle, then unmute.
module video_path_sequencer #(
   parameter int MUTE_SETTLE_CYCLES = 50000,
   parameter int STABLE_FRAMES      = 4
) (
   input  logic       clk_50mhz_in,
   input  logic       reset_x,
   input  logic       vsync_in_x,
   input  logic       signal_present,
   input  logic [7:0] video_format,
   input  logic       req_oe_x,
   input  logic       req_hd_sd_x,
   input  logic       req_rgb_comp_x,
   input  logic       req_int_ext_x,
   output logic       video_oe_x,
   output logic       hd_sd_x,
   output logic       rgb_comp_x,
   output logic       int_ext_x,
   output logic       norm_y_g,
   output logic       busy
);

   localparam int FRAME_W  = (STABLE_FRAMES > 0) ? $clog2(STABLE_FRAMES + 1) : 1;
   localparam int SETTLE_W = (MUTE_SETTLE_CYCLES > 1) ? $clog2(MUTE_SETTLE_CYCLES) : 1;
   localparam logic [FRAME_W-1:0]  FRAME_TARGET = FRAME_W'(STABLE_FRAMES);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD  = SETTLE_W'(MUTE_SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WAIT_STABLE, APPLY, SETTLE, ACTIVE} state_t;

   state_t              state;
   state_t              state_next;
   logic                vsync_meta;
   logic                vsync_sync;
   logic                vsync_prev;
   logic                frame_tick;
   logic [7:0]          captured_format;
   logic [7:0]          applied_format;
   logic [FRAME_W-1:0]  frame_count;
   logic [SETTLE_W-1:0] settle_count;
   logic                abort;
   logic                changed;
   logic                do_capture;
   logic                do_count;
   logic                do_apply;
   logic                do_settle_dec;

   // vsync is asynchronous; the tick is registered so it lands 3 cycles after the falling edge
   always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
      if (!reset_x) begin
         vsync_meta <= 1'b1;
         vsync_sync <= 1'b1;
         vsync_prev <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         vsync_meta <= vsync_in_x;
         vsync_sync <= vsync_meta;
         vsync_prev <= vsync_sync;
         frame_tick <= vsync_prev & ~vsync_sync;
      end
   end

   assign abort   = ~signal_present | req_oe_x;
   assign changed = (video_format != applied_format) | (req_hd_sd_x != hd_sd_x) |
                    (req_rgb_comp_x != rgb_comp_x) | (req_int_ext_x != int_ext_x);

   always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
      if (!reset_x) state <= IDLE;
      else          state <= state_next;
   end

   // Abort is tested first in every non-idle state so it outranks any other transition
   always_comb begin
      state_next    = state;
      do_capture    = 1'b0;
      do_count      = 1'b0;
      do_apply      = 1'b0;
      do_settle_dec = 1'b0;
      case (state)
         IDLE: begin
            if (!abort) begin
               state_next = WAIT_STABLE;
               do_capture = 1'b1;
            end
         end
         WAIT_STABLE: begin
            if (abort)                             state_next = IDLE;
            else if (frame_count >= FRAME_TARGET)  state_next = APPLY;
            else if (frame_tick) begin
               if (video_format == captured_format) do_count   = 1'b1;
               else                                 do_capture = 1'b1;
            end
         end
         APPLY: begin
            if (abort) state_next = IDLE;
            else begin
               do_apply   = 1'b1;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (abort) state_next = IDLE;
            else if (changed) begin
               state_next = WAIT_STABLE;
               do_capture = 1'b1;
            end
            else if (settle_count == '0) state_next = ACTIVE;
            else                         do_settle_dec = 1'b1;
         end
         ACTIVE: begin
            if (abort) state_next = IDLE;
            else if (changed) begin
               state_next = WAIT_STABLE;
               do_capture = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Switch outputs and normalization only move in APPLY, while the output is muted
   always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
      if (!reset_x) begin
         captured_format <= 8'h00;
         applied_format  <= 8'h00;
         frame_count     <= '0;
         settle_count    <= '0;
         hd_sd_x         <= 1'b1;
         rgb_comp_x      <= 1'b1;
         int_ext_x       <= 1'b1;
         norm_y_g        <= 1'b0;
      end else begin
         if (do_capture) begin
            captured_format <= video_format;
            frame_count     <= '0;
         end else if (do_count && (frame_count != FRAME_TARGET)) begin
            frame_count <= frame_count + 1'b1;
         end
         if (do_apply) begin
            hd_sd_x        <= req_hd_sd_x;
            rgb_comp_x     <= req_rgb_comp_x;
            int_ext_x      <= req_int_ext_x;
            applied_format <= captured_format;
            norm_y_g       <= ~(req_rgb_comp_x ? req_int_ext_x : (captured_format > 8'h05));
            settle_count   <= SETTLE_LOAD;
         end else if (do_settle_dec) begin
            settle_count <= settle_count - 1'b1;
         end
      end
   end

   assign video_oe_x = (state != ACTIVE);
   assign busy       = (state == WAIT_STABLE) || (state == APPLY) || (state == SETTLE);

endmodule

// File: tb/tb_video_path_sequencer.sv
// Scoreboard bench for video_path_sequencer: stimulus queues expected output events,
// a monitor pops one per observed output change (or snapshot) and compares.
module tb_video_path_sequencer;

   logic       clk_50mhz_in = 1'b0;
   logic       reset_x = 1'b1;
   logic       vsync_in_x = 1'b1;
   logic       signal_present = 1'b0;
   logic [7:0] video_format = 8'h00;
   logic       req_oe_x = 1'b1;
   logic       req_hd_sd_x = 1'b1;
   logic       req_rgb_comp_x = 1'b1;
   logic       req_int_ext_x = 1'b1;
   logic       video_oe_x;
   logic       hd_sd_x;
   logic       rgb_comp_x;
   logic       int_ext_x;
   logic       norm_y_g;
   logic       busy;

   video_path_sequencer #(
      .MUTE_SETTLE_CYCLES(10),
      .STABLE_FRAMES(2)
   ) dut (
      .clk_50mhz_in  (clk_50mhz_in),
      .reset_x       (reset_x),
      .vsync_in_x    (vsync_in_x),
      .signal_present(signal_present),
      .video_format  (video_format),
      .req_oe_x      (req_oe_x),
      .req_hd_sd_x   (req_hd_sd_x),
      .req_rgb_comp_x(req_rgb_comp_x),
      .req_int_ext_x (req_int_ext_x),
      .video_oe_x    (video_oe_x),
      .hd_sd_x       (hd_sd_x),
      .rgb_comp_x    (rgb_comp_x),
      .int_ext_x     (int_ext_x),
      .norm_y_g      (norm_y_g),
      .busy          (busy)
   );

   always #10 clk_50mhz_in = ~clk_50mhz_in;

   // Output vector order: {video_oe_x, hd_sd_x, rgb_comp_x, int_ext_x, norm_y_g, busy}
   logic [5:0] outv;
   assign outv = {video_oe_x, hd_sd_x, rgb_comp_x, int_ext_x, norm_y_g, busy};

   typedef struct {
      logic [5:0] vec;
      bit         snap;
      int         gap;
      int         at;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk_50mhz_in) cyc <= cyc + 1;

   task automatic push_chg(input string name, input logic [5:0] vec, input int gap, input int at);
      exp_t e;
      e.vec = vec; e.snap = 1'b0; e.gap = gap; e.at = at; e.name = name;
      sb.push_back(e);
   endtask

   task automatic push_snap(input string name, input logic [5:0] vec);
      exp_t e;
      e.vec = vec; e.snap = 1'b1; e.gap = -1; e.at = -1; e.name = name;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [5:0] last_vec;
      int         last_cyc;
      wait (mon_en);
      last_vec = outv;
      last_cyc = cyc;
      forever begin
         @(negedge clk_50mhz_in or negedge reset_x);
         #1;
         if (outv !== last_vec) begin
            if (sb.size() == 0 || sb[0].snap) begin
               checks++; errors++;
               $display("FAIL unexpected_change: outputs %b at cycle %0d, required %b (no change expected)",
                        outv, cyc, last_vec);
            end else begin
               e = sb.pop_front();
               checks++;
               if (outv !== e.vec) begin
                  errors++;
                  $display("FAIL %s: outputs %b, required %b", e.name, outv, e.vec);
               end
               if (e.gap >= 0) begin
                  checks++;
                  if (cyc - last_cyc != e.gap) begin
                     errors++;
                     $display("FAIL %s_gap: %0d cycles since previous change, required %0d",
                              e.name, cyc - last_cyc, e.gap);
                  end
               end
               if (e.at >= 0) begin
                  checks++;
                  if (cyc != e.at) begin
                     errors++;
                     $display("FAIL %s_cycle: changed at cycle %0d, required %0d", e.name, cyc, e.at);
                  end
               end
            end
            last_vec = outv;
            last_cyc = cyc;
         end
         while (sb.size() > 0 && sb[0].snap) begin
            e = sb.pop_front();
            checks++;
            if (outv !== e.vec) begin
               errors++;
               $display("FAIL %s: outputs %b, required %b", e.name, outv, e.vec);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_50mhz_in);
         #2;
      end
   endtask

   task automatic frame();
      vsync_in_x = 1'b0;
      step(4);
      vsync_in_x = 1'b1;
      step(16);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         step(1);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: %0d expected events still pending, required 0", tag, sb.size());
         sb.delete();
      end
   endtask

   initial begin : stimulus
      int  n;
      bit  seen;
      #5 reset_x = 1'b0;
      step(3);
      push_snap("reset_state", 6'b111100);
      mon_en = 1'b1;
      drain("reset");
      reset_x = 1'b1;
      step(3);

      // Bring-up: format 0x03, composite path, HD selected
      push_chg("bringup_wait", 6'b111101, -1, cyc + 1);
      signal_present = 1'b1; req_oe_x = 1'b0; video_format = 8'h03;
      req_hd_sd_x = 1'b0; req_rgb_comp_x = 1'b0; req_int_ext_x = 1'b1;
      push_chg("bringup_apply", 6'b100111, -1, -1);
      push_chg("bringup_unmute", 6'b000110, 10, -1);
      step(3);
      frame(); frame();
      drain("bringup");

      // Format change while active
      push_chg("fmt_mute", 6'b100111, -1, cyc + 1);
      video_format = 8'h07;
      push_chg("fmt_apply", 6'b100101, -1, -1);
      push_chg("fmt_unmute", 6'b000100, 10, -1);
      frame(); frame();
      drain("fmt");

      // Format never stable for two frames in a row
      push_chg("unstable_mute", 6'b100101, -1, cyc + 1);
      for (int i = 0; i < 10; i++) begin
         video_format = (i % 2 == 0) ? 8'h02 : 8'h04;
         frame();
      end
      push_snap("unstable_hold", 6'b100101);
      drain("unstable");

      // Signal loss while settling
      video_format = 8'h03;
      push_chg("loss_apply", 6'b100111, -1, -1);
      frame(); frame();
      vsync_in_x = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 60) begin
         step(1);
         n++;
         if (norm_y_g === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL loss_settle_entry: norm_y_g %b, required 1 within 60 cycles", norm_y_g);
      end
      step(4);
      push_chg("loss_idle", 6'b100110, -1, cyc + 1);
      signal_present = 1'b0;
      vsync_in_x = 1'b1;
      step(5);
      push_snap("loss_hold", 6'b100110);
      drain("loss");

      // Request toggle while active (RGB path, internal then external)
      req_rgb_comp_x = 1'b1; req_int_ext_x = 1'b0;
      step(1);
      push_chg("req_wait", 6'b100111, -1, cyc + 1);
      signal_present = 1'b1;
      push_chg("req_apply0", 6'b101011, -1, -1);
      push_chg("req_unmute0", 6'b001010, 10, -1);
      frame(); frame();
      drain("req0");
      push_chg("req_toggle_mute", 6'b101011, -1, cyc + 1);
      req_int_ext_x = 1'b1;
      push_chg("req_apply1", 6'b101101, -1, -1);
      push_chg("req_unmute1", 6'b001100, 10, -1);
      frame(); frame();
      drain("req1");

      // Host withdraws output enable, then requests it again
      push_chg("oe_abort", 6'b101100, -1, cyc + 1);
      req_oe_x = 1'b1;
      drain("oe_abort");
      step(2);
      push_chg("oe_rewait", 6'b101101, -1, cyc + 1);
      req_oe_x = 1'b0;
      push_chg("oe_unmute", 6'b001100, -1, -1);
      frame(); frame();
      drain("oe_again");

      // Asynchronous reset while active
      @(posedge clk_50mhz_in);
      #3;
      push_chg("async_reset", 6'b111100, -1, cyc);
      reset_x = 1'b0;
      step(3);
      drain("async_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
